fa_response_checker: RTL

Synthesizable self-checking response checker for the 1-bit full adder. It drives every one of the 8 input combinations into a full-adder instance and samples that adder's S/Cout. Each sample is compared against the golden values S = A^B^Cin and Cout = maj(A,B,Cin), and errors are counted. It is the response side of the exhaustive full-adder stimulus: the block replaces a simulation-only sweep with an on-chip pass/fail check.

---
 rtl/fa_response_checker.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fa_response_checker.sv
// fa_response_checker
// On-chip exhaustive response checker for a 1-bit full adder. It walks
// {a,b,cin} through 000..111 and holds each vector for SETTLE cycles plus one
// CHECK cycle. At the edge that ends CHECK it compares the adder's sum and
// carry against the golden values. It reports a mismatch count, the first
// failing vector and a pass/fail verdict.
module fa_response_checker #(
  parameter int unsigned SETTLE = 1  // hold cycles per vector, 1..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_s,
  input  logic       dut_cout,
  output logic       a,
  output logic       b,
  output logic       cin,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       fail,
  output logic [3:0] err_count,
  output logic [2:0] first_fail
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [3:0] ERR_MAX     = 4'd8;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] vec_q, vec_d;
  logic [3:0] err_q, err_d;
  logic [2:0] ff_q, ff_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic       fail_q, fail_d;

  logic       gold_s;
  logic       gold_cout;
  logic       mismatch;

  // Golden full-adder response for the vector currently on a/b/cin.
  always_comb begin
    gold_s    = vec_q[2] ^ vec_q[1] ^ vec_q[0];
    gold_cout = (vec_q[2] & vec_q[1]) | (vec_q[2] & vec_q[0]) | (vec_q[1] & vec_q[0]);
    // A sum error and a carry error on the same vector count as one error.
    mismatch  = (dut_s != gold_s) | (dut_cout != gold_cout);
  end

  // Next-state logic: sequencing, compare and verdict bookkeeping.
  always_comb begin
    // NOTE: every signal gets a hold default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    err_d   = err_q;
    ff_d    = ff_q;
    busy_d  = busy_q;
    done_d  = done_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        // A start in IDLE or DONE clears the previous verdict and relaunches.
        if (start) begin
          state_d = ST_SETTLE;
          cnt_d   = 4'd0;
          vec_d   = 3'd0;
          err_d   = 4'd0;
          ff_d    = 3'd0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_CHECK;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_CHECK: begin
        if (mismatch) begin
          if (err_q == 4'd0) ff_d = vec_q;
          if (err_q != ERR_MAX) err_d = err_q + 4'd1;
        end
        // The last vector stays on the pins so vec never wraps.
        if (vec_q == 3'd7) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          vec_d   = vec_q + 3'd1;
          state_d = ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    pass_d = done_d & (err_d == 4'd0);
    fail_d = done_d & (err_d != 4'd0);
  end

  // State and output registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments keep every flop sampling the
    // pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      vec_q   <= 3'd0;
      err_q   <= 4'd0;
      ff_q    <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  assign a          = vec_q[2];
  assign b          = vec_q[1];
  assign cin        = vec_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail       = fail_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;

endmodule
